// File: rtl/golden_nonce_detector.sv
// golden_nonce_detector: tracks issued nonces through a latency-matched delay line,
// checks the final hash against the difficulty mask and queues golden nonces.
module golden_nonce_detector #(
   parameter int LATENCY   = 8,
   parameter int DEPTH     = 4,
   parameter int DIFF_BITS = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         issue,
   input  logic [31:0]  nonce_in,
   input  logic         new_work,
   input  logic [255:0] hash,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [31:0]  out_nonce,
   output logic         overflow,
   output logic [31:0]  hash_count
);
   localparam int AW = $clog2(DEPTH);
   logic [LATENCY-1:0]       vld_q, vld_d;
   logic [LATENCY-1:0][31:0] nz_q, nz_d;
   logic                     hit_q, hit_d;
   logic [31:0]              nonce_q;
   logic [31:0]              mem_q [DEPTH];
   logic [AW:0]              wp_q, wp_d, rp_q, rp_d;
   logic                     ovf_q, ovf_d;
   logic [31:0]              cnt_q, cnt_d;
   logic                     empty, full, push, pop, unused_hash;
   assign unused_hash = ^hash;
   always_comb begin
      vld_d    = new_work ? '0 : vld_q << 1;
      vld_d[0] = issue;
      nz_d     = nz_q << 32;
      nz_d[0]  = nonce_in;
      hit_d    = !new_work && vld_q[LATENCY-1] && hash[255 -: DIFF_BITS] == '0;
      empty    = wp_q == rp_q;
      full     = wp_q == {~rp_q[AW], rp_q[AW-1:0]};
      pop      = !empty && out_ready;
      // a full FIFO still takes the push when the head leaves in the same cycle
      push     = hit_q && (!full || pop);
      wp_d     = wp_q + {{AW{1'b0}}, push};
      rp_d     = rp_q + {{AW{1'b0}}, pop};
      ovf_d    = ovf_q | (hit_q & full & !pop);
      cnt_d    = cnt_q + 32'(vld_q[LATENCY-1]);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q <= '0;
         hit_q <= 1'b0;
         wp_q  <= '0;
         rp_q  <= '0;
         ovf_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         vld_q <= vld_d;
         hit_q <= hit_d;
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         ovf_q <= ovf_d;
         cnt_q <= cnt_d;
      end
   end
   always_ff @(posedge clk) begin
      nz_q    <= nz_d;
      nonce_q <= nz_q[LATENCY-1];
      if (push && !reset) mem_q[wp_q[AW-1:0]] <= nonce_q;
   end
   assign out_valid  = !empty;
   assign out_nonce  = empty ? '0 : mem_q[rp_q[AW-1:0]];
   assign overflow   = ovf_q;
   assign hash_count = cnt_q;
endmodule

// File: doc/golden_nonce_detector.md
# golden_nonce_detector

Sits directly downstream of the second SHA-256 transform in the miner datapath. It tracks each nonce issued into the hashing pipeline through a latency-matched delay line and tests the matching final hash against the difficulty mask. Nonces that pass are queued in a small FIFO behind a valid/ready handshake. The serial/cgminer reporting logic drains that FIFO. The block also keeps a free-running count of checked hashes for hashrate reporting.

## Interface
- LATENCY, 8: cycles from a nonce being issued into the pipeline to its final hash appearing on `hash`; legal range 1–255.
- DEPTH, 4: golden-nonce FIFO entries; must be a power of 2, at least 2.
- DIFF_BITS, 32: number of leading bits of `hash` that must be zero; legal range 1–32.

- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- issue  in  1  a nonce entered the hashing pipeline this cycle.
- nonce_in  in  32  the nonce issued; sampled only when `issue`=1.
- new_work  in  1  new work loaded; invalidates all in-flight nonces.
- hash  in  256  final (second-transform) hash; `hash[255:224]` is the most significant word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head entry when `out_valid`=1.
- out_nonce  out  32  FIFO head nonce; 0 when empty.
- overflow  out  1  sticky: a golden nonce was dropped because the FIFO was full.
- hash_count  out  32  number of valid hashes checked; wraps modulo 2^32.

## Operation
- **Delay line.** LATENCY stages, each holding {valid, nonce[31:0]}.
  - Stage 0 loads {`issue`, `nonce_in`} every cycle.
  - Each later stage copies the previous stage.
  - The output of stage LATENCY-1 is aligned with `hash`.
- **Compare.** Combinational hit = tail valid AND `hash[255:256-DIFF_BITS]` == 0. The hit and the tail nonce are then registered as `hit_q` / `nonce_q`.
- **hash_count.** Increments by 1 in every cycle the tail valid bit is 1. This is independent of hit.
- **FIFO write.** Occurs when `hit_q`=1.
  - If the FIFO is full and no pop happens in the same cycle, the entry is dropped and `overflow` is set to 1.
  - If the FIFO is full and a pop happens in the same cycle, both the push and the pop are performed and `overflow` is unchanged.
- **FIFO read.** Pop when `out_valid` AND `out_ready`.
  - `out_nonce` always shows the head entry.
  - Read and write pointers are log2(DEPTH)+1 bits; full/empty are derived from the MSB difference.
- **Push and pop in the same cycle:**
  - Non-empty, non-full FIFO: occupancy is unchanged.
  - Empty FIFO: the push is accepted and the pop is not possible, since `out_valid` is 0.
- **new_work=1.** In that cycle:
  - All delay-line valid bits are cleared, and `hit_q` is cleared.
  - An `issue` presented in the same cycle is still loaded into stage 0 as valid.
  - The FIFO and `overflow` are not affected; stale-work filtering belongs to the host.
- **reset=1** (including mid-operation), at the next edge:
  - All delay-line valid bits, `hit_q` and the FIFO pointers are set to 0.
  - `out_valid`=0, `out_nonce`=0, `overflow`=0, `hash_count`=0.
  - reset has priority over every other input.
- **overflow** is cleared only by reset.

## Timing
- Let a nonce be sampled with `issue`=1 at edge t (the end of cycle t).
- Its hash is compared during cycle t+LATENCY.
- `hit_q` is high in cycle t+LATENCY+1.
- The FIFO is written at the end of that cycle.
- If the FIFO was empty, `out_valid`=1 and `out_nonce`=nonce in cycle t+LATENCY+2. Total added latency is 2 cycles after the hash.
- `hash_count` reflects the check one cycle after the compare cycle.
- Throughput: one nonce per cycle sustained, with no backpressure toward the pipeline. `out_ready` low never stalls `issue`.
- `out_valid` drops in the cycle after the last entry is popped, unless a push occurs in the same cycle.

## Test plan
- **Single hit.** `issue` with nonce 0x1234_5678 at cycle 0; `hash[255:224]`=0 in cycle 8; `out_ready`=1 → `out_valid`=1 with `out_nonce`=0x1234_5678 in cycle 10 only. `hash_count` increments by 1.
- **Non-hit and DIFF_BITS.** Stream of 100 consecutive nonces 0..99; hash top word 0x0000_0001 at every compare.
  - With DIFF_BITS=32 → no `out_valid`, `hash_count`=100.
  - With DIFF_BITS=31 → 100 golden nonces appear in order.
- **Overflow.** DEPTH=4, `out_ready`=0, 6 consecutive hits on nonces 10..15 → FIFO holds 10, 11, 12, 13 and `overflow`=1. Then raise `out_ready` → 10, 11, 12, 13 drain on 4 consecutive cycles, then `out_valid`=0.
- **Simultaneous push/pop when full.** FIFO full with nonces 1, 2, 3, 4; `out_ready`=1 in the same cycle a hit for nonce 5 is registered → pop 1, accept 5, `overflow` stays 0, order is 2, 3, 4, 5.
- **new_work flush.** Issue nonces 20..27 with `new_work` pulsed at the cycle nonce 24 is issued; all compared hashes hit → only nonces 24..27 are reported, and `hash_count` advances by 4 for this burst.
- **Mid-stream reset.** Reset asserted with 3 entries queued and 5 nonces in flight → next cycle `out_valid`=0, `out_nonce`=0, `overflow`=0, `hash_count`=0. No spurious output during the following LATENCY+2 cycles.
